// File: rtl/entity_motion_ctrl.sv
// entity_motion_ctrl: tile-based motion controller for one game entity.
//
// Turns a 2-bit direction code plus a level "go" request into per-frame pixel
// steps. A tile move is one start tick followed by TILE/STEP move ticks; when
// go stays high at a tile boundary the next tile chains without an idle tick.
// Everything advances only on cycles where frame_tick_i is high.
//
// Build option: define ENTITY_MOTION_WRAP_EN to make the playfield toroidal
// (edges never block, blocked_o stays 0, positions wrap modulo MAX+TILE).
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   dir_i         requested direction: 0=up, 1=right, 2=down, 3=left
//   go_i          level, movement requested
//   frame_tick_i  one-clk pulse per video frame
//   pos_x_o       entity x, pixels
//   pos_y_o       entity y, pixels
//   facing_o      last accepted direction
//   moving_o      high while a tile step is in progress
//   step_done_o   one-clk pulse when position lands on a tile boundary
//   blocked_o     one-clk pulse when a step is refused at an edge
//   anim_frame_o  walk animation index
module entity_motion_ctrl #(
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned TILE     = 16,
  parameter int unsigned STEP     = 2,
  parameter int unsigned X_MAX    = 624,
  parameter int unsigned Y_MAX    = 464,
  parameter int unsigned X_INIT   = 320,
  parameter int unsigned Y_INIT   = 240,
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     dir_i,
  input  logic           go_i,
  input  logic           frame_tick_i,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic [1:0]     facing_o,
  output logic           moving_o,
  output logic           step_done_o,
  output logic           blocked_o,
  output logic [1:0]     anim_frame_o
);

`ifdef ENTITY_MOTION_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  localparam int unsigned RW = $clog2(TILE + 1);
  localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [RW-1:0]  TileR    = RW'(TILE);
  localparam logic [RW-1:0]  StepR    = RW'(STEP);
  localparam logic [AW-1:0]  AnimLast = AW'(ANIM_DIV - 1);

  // One extra bit so pos + TILE comparisons cannot overflow.
  localparam logic [X_W:0] TileX = (X_W + 1)'(TILE);
  localparam logic [X_W:0] StepX = (X_W + 1)'(STEP);
  localparam logic [X_W:0] XMaxX = (X_W + 1)'(X_MAX);
  localparam logic [X_W:0] XModX = (X_W + 1)'(X_MAX + TILE);
  localparam logic [Y_W:0] TileY = (Y_W + 1)'(TILE);
  localparam logic [Y_W:0] StepY = (Y_W + 1)'(STEP);
  localparam logic [Y_W:0] YMaxY = (Y_W + 1)'(Y_MAX);
  localparam logic [Y_W:0] YModY = (Y_W + 1)'(Y_MAX + TILE);

  typedef enum logic {StIdle, StMoving} state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d;
  logic [1:0]     facing_q, facing_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic           step_done_q, step_done_d;
  logic           blocked_q, blocked_d;
  logic [AW-1:0]  anim_cnt_q, anim_cnt_d;
  logic [1:0]     anim_q, anim_d;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;

  // Whether the whole destination tile lies inside the playfield.
  function automatic logic target_legal(input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                                        input logic [1:0] d);
    logic ok;
    unique case (d)
      2'd0:    ok = ({1'b0, py} >= TileY);
      2'd1:    ok = ({1'b0, px} + TileX <= XMaxX);
      2'd2:    ok = ({1'b0, py} + TileY <= YMaxY);
      default: ok = ({1'b0, px} >= TileX);
    endcase
    return ok;
  endfunction

  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] px, input logic [1:0] d);
    logic [X_W:0] s;
    s = {1'b0, px};
    if (d == 2'd1) begin
      s = s + StepX;
      if (WrapEn && (s >= XModX)) s = s - XModX;
    end else if (d == 2'd3) begin
      if (WrapEn && (s < StepX)) s = s + XModX - StepX;
      else                       s = s - StepX;
    end
    return X_W'(s);
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] py, input logic [1:0] d);
    logic [Y_W:0] s;
    s = {1'b0, py};
    if (d == 2'd2) begin
      s = s + StepY;
      if (WrapEn && (s >= YModY)) s = s - YModY;
    end else if (d == 2'd0) begin
      if (WrapEn && (s < StepY)) s = s + YModY - StepY;
      else                       s = s - StepY;
    end
    return Y_W'(s);
  endfunction

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    facing_d    = facing_q;
    rem_d       = rem_q;
    step_done_d = 1'b0;
    blocked_d   = 1'b0;
    anim_cnt_d  = anim_cnt_q;
    anim_d      = anim_q;
    nx          = step_x(pos_x_q, facing_q);
    ny          = step_y(pos_y_q, facing_q);

    if (frame_tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            facing_d = dir_i;
            if (WrapEn || target_legal(pos_x_q, pos_y_q, dir_i)) begin
              state_d = StMoving;
              rem_d   = TileR;
            end else begin
              blocked_d = 1'b1;
            end
          end
        end
        StMoving: begin
          pos_x_d = nx;
          pos_y_d = ny;
          rem_d   = rem_q - StepR;
          if (rem_q == StepR) begin
            step_done_d = 1'b1;
            state_d     = StIdle;
            // Chain decision uses the post-increment position and the live dir.
            if (go_i) begin
              facing_d = dir_i;
              if (WrapEn || target_legal(nx, ny, dir_i)) begin
                state_d = StMoving;
                rem_d   = TileR;
              end else begin
                blocked_d = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase

      // Counts every tick that leaves us MOVING, including the start tick, and
      // survives chaining; entering IDLE clears it.
      if (state_d == StMoving) begin
        if (anim_cnt_q == AnimLast) begin
          anim_cnt_d = '0;
          anim_d     = anim_q + 2'd1;
        end else begin
          anim_cnt_d = anim_cnt_q + AW'(1);
        end
      end else begin
        anim_cnt_d = '0;
        anim_d     = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pos_x_q     <= X_W'(X_INIT);
      pos_y_q     <= Y_W'(Y_INIT);
      facing_q    <= 2'd2;
      rem_q       <= '0;
      step_done_q <= 1'b0;
      blocked_q   <= 1'b0;
      anim_cnt_q  <= '0;
      anim_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      facing_q    <= facing_d;
      rem_q       <= rem_d;
      step_done_q <= step_done_d;
      blocked_q   <= blocked_d;
      anim_cnt_q  <= anim_cnt_d;
      anim_q      <= anim_d;
    end
  end

  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign facing_o     = facing_q;
  assign moving_o     = (state_q == StMoving);
  assign step_done_o  = step_done_q;
  assign blocked_o    = blocked_q;
  assign anim_frame_o = anim_q;

endmodule

// File: doc/entity_motion_ctrl.md
# entity_motion_ctrl

Tile-based motion controller for one game entity. It sits directly downstream of the 2-bit entity-direction PIO register and the frame-tick source. It turns a direction code plus a go request into per-frame pixel steps of the entity's screen position. Its outputs drive the sprite renderer: position, facing, moving flag and animation frame.

## Interface
Parameters:
- X_W, 10, pos_x width
- Y_W, 9, pos_y width
- TILE, 16, pixels per tile move; must be a multiple of STEP
- STEP, 2, pixels moved per frame tick
- X_MAX, 624, largest legal pos_x; multiple of TILE
- Y_MAX, 464, largest legal pos_y; multiple of TILE
- X_INIT, 320, reset pos_x; multiple of TILE
- Y_INIT, 240, reset pos_y; multiple of TILE
- ANIM_DIV, 8, frame ticks per animation frame advance

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- dir  in  2  requested direction: 0=up (y−), 1=right (x+), 2=down (y+), 3=left (x−)
- go  in  1  level; movement requested
- frame_tick  in  1  one-clk pulse per video frame
- pos_x  out  X_W  entity x, pixels
- pos_y  out  Y_W  entity y, pixels
- facing  out  2  last accepted direction
- moving  out  1  high while a tile step is in progress
- step_done  out  1  one-clk pulse when position lands on a tile boundary
- blocked  out  1  one-clk pulse when a step is refused at an edge
- anim_frame  out  2  walk animation index

## Operation
- States: IDLE, MOVING. Internal remaining-pixel counter rem, sized for TILE.
- All inputs are sampled only on cycles with frame_tick=1. On all other cycles, state and outputs hold; the step_done and blocked pulses are 0.
- IDLE, tick, go=0: no change.
- IDLE, tick, go=1:
  - facing<=dir.
  - If the target tile is legal: →MOVING, rem<=TILE. Position is unchanged on this tick.
  - If the target tile is illegal: stay IDLE and pulse blocked.
- Target tile legality:
  - up: legal iff pos_y≥TILE.
  - down: legal iff pos_y+TILE≤Y_MAX.
  - left: legal iff pos_x≥TILE.
  - right: legal iff pos_x+TILE≤X_MAX.
- MOVING, tick:
  - pos moves STEP pixels in direction facing; rem<=rem−STEP.
  - dir is ignored mid-tile.
- MOVING, tick with rem==STEP (final increment): pulse step_done on the same edge, then:
  - go=1 and the next target is legal (evaluated from the post-increment position using the current dir): stay MOVING, facing<=dir, rem<=TILE. Chaining costs no idle tick.
  - go=1 and the next target is illegal: →IDLE, facing<=dir, pulse blocked.
  - go=0: →IDLE.
- anim_frame:
  - A tick counter runs in MOVING; anim_frame increments every ANIM_DIV ticks and wraps 3→0.
  - The counter and anim_frame clear to 0 on entry to IDLE. They are not cleared when a step chains.
- moving = (state==MOVING).
- Arithmetic is unsigned. pos stays on a tile multiple whenever the block is in IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, pos_x=X_INIT, pos_y=Y_INIT, facing=2, moving=0, step_done=0, blocked=0, anim_frame=0, rem=0.
- A reset mid-step abandons the step immediately. The position returns to X_INIT/Y_INIT and no step_done pulse is issued.
- All outputs are registered, and the update is visible the clk after the frame_tick edge.
- One tile = 1 start tick + TILE/STEP move ticks. With defaults that is 9 ticks for an isolated step and 8 ticks per tile once chained.
- frame_tick held high for several clks counts as several ticks. The source must pulse it for exactly one clk.

## Configuration
- ENTITY_MOTION_WRAP_EN defined:
  - Edges do not block, and blocked is tied to 0.
  - pos_x wraps modulo X_MAX+TILE; pos_y wraps modulo Y_MAX+TILE. Example: left from pos_x=0 gives X_MAX+TILE−STEP after the first increment.
- ENTITY_MOTION_WRAP_EN undefined: edge blocking as described in Operation.

## Test plan
- Reset, then go=1, dir=1, 9 ticks -> pos_x 320→336 in +2 steps, step_done on tick 9, moving falls, anim_frame 0→1 after tick 8, then 0 in IDLE.
- go held, dir=0 for 3 tiles -> pos_y 240→192, step_done every 8 ticks after the first 9, moving never drops.
- dir changed from 1 to 2 mid-tile -> x step completes to 336; the next tile moves down, facing=2 only at the boundary.
- pos_x=0, dir=3, go=1 -> blocked pulse, facing=3, pos unchanged, moving=0. With ENTITY_MOTION_WRAP_EN: pos_x=638 after the first move tick and 624 at step_done.
- reset_n asserted at rem=8 of a move -> immediate pos=(320,240), facing=2, moving=0, no step_done.
- frame_tick=0 for 100 clks while MOVING -> all outputs frozen.
